// File: rtl/i2s_audio_receiver.sv
`default_nettype none
// ============================================================================
// Module   : i2s_audio_receiver
// Purpose  : Deserialises a 16-bit stereo I2S / left-justified serial stream
//            (SCK/LRCK/SDIN, all asynchronous to clk) into parallel left and
//            right samples, flags short slots, and keeps a windowed peak
//            meter per channel.
// Revision : 1.0 - initial release
// ============================================================================
module i2s_audio_receiver #(
  parameter int DATA_DELAY  = 0,    // SCK rises skipped after LRCK edge (0 or 1)
  parameter int PEAK_FRAMES = 4096  // frames per peak window, 1..65536
) (
  input  logic        clk,
  input  logic        rst_one_pulsed,
  input  logic        en,
  input  logic        audio_sck,
  input  logic        audio_lrck,
  input  logic        audio_sdin,
  output logic [15:0] sample_left,
  output logic [15:0] sample_right,
  output logic        sample_valid,
  output logic        frame_err,
  output logic [15:0] peak_left,
  output logic [15:0] peak_right
);

  // Bit position (relative to the LRCK edge) of the MSB, and the frame index
  // on which a peak window closes.
  localparam logic [4:0]  c_FIRST_BIT  = 5'(DATA_DELAY);
  localparam logic [16:0] c_LAST_FRAME = 17'(PEAK_FRAMES - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LEFT  = 2'd1,
    ST_RIGHT = 2'd2
  } state_t;

  // Two's-complement magnitude; -32768 saturates so the result fits 16 bits.
  function automatic logic [15:0] f_abs(input logic [15:0] x);
    if (x == 16'h8000) begin
      return 16'h7FFF;
    end else if (x[15]) begin
      return ~x + 16'd1;
    end
    return x;
  endfunction

  // Synchroniser chains: bit 0 = s1, bit 1 = s2, bit 2 = s3.
  logic [2:0]  r_sck_sync;
  logic [2:0]  r_lrck_sync;
  logic [2:0]  r_sdin_sync;

  state_t      r_state;
  state_t      w_state_nxt;

  logic [4:0]  r_bit_cnt;
  logic [15:0] r_shift;
  logic        r_slot_done;
  logic [15:0] r_left_hold;
  logic        r_left_ok;

  logic [15:0] r_sample_left;
  logic [15:0] r_sample_right;
  logic        r_sample_valid;
  logic        r_frame_err;

  logic [15:0] r_pk_l;
  logic [15:0] r_pk_r;
  logic [16:0] r_frame_cnt;
  logic [15:0] r_peak_left;
  logic [15:0] r_peak_right;

  // Edge detection on the synchronised pins.
  logic        w_sck_rise;
  logic        w_lr_rise;
  logic        w_lr_fall;
  logic        w_lr_edge;
  logic        w_bit;

  // Slot datapath.
  logic [4:0]  w_cnt_base;
  logic [4:0]  w_cnt_rel;
  logic [4:0]  w_cnt_nxt;
  logic        w_shift_en;
  logic [15:0] w_shift_nxt;
  logic        w_word_done;
  logic        w_left_done;
  logic        w_right_done;
  logic        w_frame_go;
  logic        w_short;

  // Peak datapath.
  logic [15:0] w_abs_l;
  logic [15:0] w_abs_r;
  logic [15:0] w_max_l;
  logic [15:0] w_max_r;

  assign w_sck_rise = r_sck_sync[1] & ~r_sck_sync[2];
  assign w_lr_rise  = r_lrck_sync[1] & ~r_lrck_sync[2];
  assign w_lr_fall  = ~r_lrck_sync[1] & r_lrck_sync[2];
  assign w_lr_edge  = w_lr_rise | w_lr_fall;
  assign w_bit      = r_sdin_sync[1];

  // An LRCK edge is processed before a coincident SCK rise, so that rise is
  // counted from zero as the first edge of the new slot.
  assign w_cnt_base  = w_lr_edge ? 5'd0 : r_bit_cnt;
  assign w_cnt_rel   = w_cnt_base - c_FIRST_BIT;   // wraps high before the MSB
  assign w_cnt_nxt   = (w_cnt_base == 5'd31) ? 5'd31 : w_cnt_base + 5'd1;
  assign w_shift_en  = w_sck_rise && (w_cnt_rel < 5'd16);
  assign w_shift_nxt = {r_shift[14:0], w_bit};
  assign w_word_done = en && w_shift_en && (w_cnt_rel == 5'd15);
  assign w_left_done = w_word_done && (r_state == ST_LEFT);
  assign w_right_done = w_word_done && (r_state == ST_RIGHT);
  assign w_frame_go  = w_right_done && r_left_ok;

  assign w_abs_l = f_abs(r_left_hold);
  assign w_abs_r = f_abs(w_shift_nxt);
  assign w_max_l = (w_abs_l > r_pk_l) ? w_abs_l : r_pk_l;
  assign w_max_r = (w_abs_r > r_pk_r) ? w_abs_r : r_pk_r;

  // Bring the three serial pins into the clk domain.
  always_ff @(posedge clk or posedge rst_one_pulsed) begin
    if (rst_one_pulsed) begin
      r_sck_sync  <= 3'd0;
      r_lrck_sync <= 3'd0;
      r_sdin_sync <= 3'd0;
    end else begin
      r_sck_sync  <= {r_sck_sync[1:0], audio_sck};
      r_lrck_sync <= {r_lrck_sync[1:0], audio_lrck};
      r_sdin_sync <= {r_sdin_sync[1:0], audio_sdin};
    end
  end

  // Slot state register.
  always_ff @(posedge clk or posedge rst_one_pulsed) begin
    if (rst_one_pulsed) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Slot sequencing; capture only starts on a left-slot LRCK fall.
  always_comb begin
    w_state_nxt = r_state;
    w_short     = 1'b0;
    if (!en) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_lr_fall) w_state_nxt = ST_LEFT;
        end
        ST_LEFT: begin
          if (w_lr_rise) w_state_nxt = ST_RIGHT;
          w_short = w_lr_edge && !r_slot_done;
        end
        ST_RIGHT: begin
          if (w_lr_fall) w_state_nxt = ST_LEFT;
          w_short = w_lr_edge && !r_slot_done;
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  // Bit counter, shift register and per-slot completion flag.
  always_ff @(posedge clk or posedge rst_one_pulsed) begin
    if (rst_one_pulsed) begin
      r_bit_cnt   <= 5'd0;
      r_shift     <= 16'd0;
      r_slot_done <= 1'b0;
    end else begin
      if (w_sck_rise) begin
        r_bit_cnt <= w_cnt_nxt;
      end else if (w_lr_edge) begin
        r_bit_cnt <= 5'd0;
      end
      if (w_shift_en) begin
        r_shift <= w_shift_nxt;
      end
      if (w_lr_edge || !en) begin
        r_slot_done <= 1'b0;
      end else if (w_word_done) begin
        r_slot_done <= 1'b1;
      end
    end
  end

  // Hold the left word until its right partner arrives.
  always_ff @(posedge clk or posedge rst_one_pulsed) begin
    if (rst_one_pulsed) begin
      r_left_hold <= 16'd0;
      r_left_ok   <= 1'b0;
    end else if (!en) begin
      r_left_ok <= 1'b0;
    end else if (w_left_done) begin
      r_left_hold <= w_shift_nxt;
      r_left_ok   <= 1'b1;
    end else if (w_right_done) begin
      r_left_ok <= 1'b0;
    end else if (w_short && (r_state == ST_LEFT)) begin
      r_left_ok <= 1'b0;
    end
  end

  // Publish complete stereo frames and short-slot errors.
  always_ff @(posedge clk or posedge rst_one_pulsed) begin
    if (rst_one_pulsed) begin
      r_sample_left  <= 16'd0;
      r_sample_right <= 16'd0;
      r_sample_valid <= 1'b0;
      r_frame_err    <= 1'b0;
    end else begin
      r_sample_valid <= w_frame_go;
      r_frame_err    <= w_short;
      if (w_frame_go) begin
        r_sample_left  <= r_left_hold;
        r_sample_right <= w_shift_nxt;
      end
    end
  end

  // Peak accumulation; the window result includes its closing frame.
  always_ff @(posedge clk or posedge rst_one_pulsed) begin
    if (rst_one_pulsed) begin
      r_pk_l       <= 16'd0;
      r_pk_r       <= 16'd0;
      r_frame_cnt  <= 17'd0;
      r_peak_left  <= 16'd0;
      r_peak_right <= 16'd0;
    end else if (w_frame_go) begin
      if (r_frame_cnt == c_LAST_FRAME) begin
        r_peak_left  <= w_max_l;
        r_peak_right <= w_max_r;
        r_pk_l       <= 16'd0;
        r_pk_r       <= 16'd0;
        r_frame_cnt  <= 17'd0;
      end else begin
        r_pk_l      <= w_max_l;
        r_pk_r      <= w_max_r;
        r_frame_cnt <= r_frame_cnt + 17'd1;
      end
    end
  end

  assign sample_left  = r_sample_left;
  assign sample_right = r_sample_right;
  assign sample_valid = r_sample_valid;
  assign frame_err    = r_frame_err;
  assign peak_left    = r_peak_left;
  assign peak_right   = r_peak_right;

endmodule
`default_nettype wire

// File: tb/tb_i2s_audio_receiver.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2s_audio_receiver
// Purpose  : Directed bench for i2s_audio_receiver. Two instances share the
//            serial clocks: u0 (left-justified) and u1 (one-bit delay); each
//            gets its own data line laid out for its delay.
// Revision : 1.0 - initial release
// ============================================================================
module tb_i2s_audio_receiver;

  logic        clk = 1'b0;
  logic        rst_one_pulsed = 1'b1;
  logic        en = 1'b0;
  logic        audio_sck = 1'b0;
  logic        audio_lrck = 1'b1;
  logic        sdin0 = 1'b0;
  logic        sdin1 = 1'b0;

  logic [15:0] sl0, sr0, pl0, pr0;
  logic        sv0, fe0;
  logic [15:0] sl1, sr1, pl1, pr1;
  logic        sv1, fe1;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int last_rise_cyc = 0;

  int vcnt0 = 0, ecnt0 = 0, vcyc0 = 0, viol0 = 0, chg0 = 0;
  int vcnt1 = 0, ecnt1 = 0;

  i2s_audio_receiver #(.DATA_DELAY(0), .PEAK_FRAMES(4)) u0 (
    .clk(clk), .rst_one_pulsed(rst_one_pulsed), .en(en),
    .audio_sck(audio_sck), .audio_lrck(audio_lrck), .audio_sdin(sdin0),
    .sample_left(sl0), .sample_right(sr0), .sample_valid(sv0),
    .frame_err(fe0), .peak_left(pl0), .peak_right(pr0)
  );

  i2s_audio_receiver #(.DATA_DELAY(1), .PEAK_FRAMES(4)) u1 (
    .clk(clk), .rst_one_pulsed(rst_one_pulsed), .en(en),
    .audio_sck(audio_sck), .audio_lrck(audio_lrck), .audio_sdin(sdin1),
    .sample_left(sl1), .sample_right(sr1), .sample_valid(sv1),
    .frame_err(fe1), .peak_left(pl1), .peak_right(pr1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse counters and stability watch for u0, sampled just after each edge.
  logic        psv0 = 1'b0, pfe0 = 1'b0, prst = 1'b1;
  logic [15:0] psl0 = 16'd0, psr0 = 16'd0, ppl0 = 16'd0, ppr0 = 16'd0;
  always @(posedge clk) begin
    #1;
    if (sv0) begin
      vcnt0 = vcnt0 + 1;
      vcyc0 = cyc;
    end
    if (fe0) ecnt0 = ecnt0 + 1;
    if ((sv0 && psv0) || (fe0 && pfe0)) viol0 = viol0 + 1;
    if (!rst_one_pulsed && !prst && !sv0 &&
        (sl0 !== psl0 || sr0 !== psr0 || pl0 !== ppl0 || pr0 !== ppr0))
      chg0 = chg0 + 1;
    psv0 = sv0; pfe0 = fe0; prst = rst_one_pulsed;
    psl0 = sl0; psr0 = sr0; ppl0 = pl0; ppr0 = pr0;
  end

  // Pulse counters for u1.
  always @(posedge clk) begin
    #1;
    if (sv1) vcnt1 = vcnt1 + 1;
    if (fe1) ecnt1 = ecnt1 + 1;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic bit_at(input logic [15:0] w, input int i,
                                  input int d, input logic fill);
    if (i < d || i >= d + 16) return fill;
    return w[15 - (i - d)];
  endfunction

  // Transmit slot bits [start, start+n): data/LRCK change on SCK fall,
  // SCK period 16 clk.
  task automatic send_bits(input logic lr, input logic [15:0] w,
                           input int start, input int n, input logic fill);
    for (int i = start; i < start + n; i++) begin
      @(negedge clk);
      audio_sck  = 1'b0;
      audio_lrck = lr;
      sdin0      = bit_at(w, i, 0, fill);
      sdin1      = bit_at(w, i, 1, fill);
      tick(7);
      @(negedge clk);
      audio_sck     = 1'b1;
      last_rise_cyc = cyc;
      tick(7);
    end
  endtask

  task automatic send_frame(input logic [15:0] l, input logic [15:0] r,
                            input int n, input logic fill);
    send_bits(1'b0, l, 0, n, fill);
    send_bits(1'b1, r, 0, n, fill);
  endtask

  task automatic test_reset;
    rst_one_pulsed = 1'b1;
    en = 1'b0;
    tick(5);
    checks++; if (sl0 !== 16'h0000) begin errors++; $display("FAIL reset_sample_left: got %h expected 0000", sl0); end
    checks++; if (sr0 !== 16'h0000) begin errors++; $display("FAIL reset_sample_right: got %h expected 0000", sr0); end
    checks++; if (sv0 !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", sv0); end
    checks++; if (fe0 !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %b expected 0", fe0); end
    checks++; if (pl0 !== 16'h0000 || pr0 !== 16'h0000) begin errors++; $display("FAIL reset_peaks: got %h/%h expected 0000/0000", pl0, pr0); end
    rst_one_pulsed = 1'b0;
    tick(2);
    en = 1'b1;
    tick(2);
  endtask

  task automatic test_left_justified;
    int b, e, lat;
    b = vcnt0; e = ecnt0;
    send_frame(16'h8001, 16'h7FFE, 16, 1'b0);
    lat = vcyc0 - last_rise_cyc;
    checks++; if (vcnt0 - b !== 1) begin errors++; $display("FAIL lj_valid_count1: got %0d expected 1", vcnt0 - b); end
    checks++; if (lat < 3 || lat > 5) begin errors++; $display("FAIL lj_latency: got %0d expected 3..5", lat); end
    checks++; if (sl0 !== 16'h8001) begin errors++; $display("FAIL lj_left: got %h expected 8001", sl0); end
    checks++; if (sr0 !== 16'h7FFE) begin errors++; $display("FAIL lj_right: got %h expected 7ffe", sr0); end
    send_frame(16'h8001, 16'h7FFE, 16, 1'b0);
    checks++; if (vcnt0 - b !== 2) begin errors++; $display("FAIL lj_valid_count2: got %0d expected 2", vcnt0 - b); end
    checks++; if (ecnt0 - e !== 0) begin errors++; $display("FAIL lj_no_err: got %0d expected 0", ecnt0 - e); end
    checks++; if (pl0 !== 16'h0000) begin errors++; $display("FAIL lj_peak_hold: got %h expected 0000", pl0); end
  endtask

  task automatic test_delayed_wide;
    int b0, e0, b1, e1;
    en = 1'b0; tick(2); en = 1'b1; tick(2);
    b0 = vcnt0; e0 = ecnt0; b1 = vcnt1; e1 = ecnt1;
    send_frame(16'h1234, 16'hABCD, 32, 1'b1);
    send_frame(16'h1234, 16'hABCD, 32, 1'b1);
    checks++; if (vcnt1 - b1 !== 2) begin errors++; $display("FAIL dly_valid_count: got %0d expected 2", vcnt1 - b1); end
    checks++; if (ecnt1 - e1 !== 0) begin errors++; $display("FAIL dly_no_err: got %0d expected 0", ecnt1 - e1); end
    checks++; if (sl1 !== 16'h1234) begin errors++; $display("FAIL dly_left: got %h expected 1234", sl1); end
    checks++; if (sr1 !== 16'hABCD) begin errors++; $display("FAIL dly_right: got %h expected abcd", sr1); end
    checks++; if (vcnt0 - b0 !== 2 || sl0 !== 16'h1234 || sr0 !== 16'hABCD) begin errors++; $display("FAIL wide_lj: got %0d %h %h expected 2 1234 abcd", vcnt0 - b0, sl0, sr0); end
    checks++; if (ecnt0 - e0 !== 0) begin errors++; $display("FAIL wide_lj_no_err: got %0d expected 0", ecnt0 - e0); end
    checks++; if (pl0 !== 16'h7FFF || pr0 !== 16'h7FFE) begin errors++; $display("FAIL first_window_peaks: got %h/%h expected 7fff/7ffe", pl0, pr0); end
  endtask

  task automatic test_short_slot;
    int b, e;
    b = vcnt0; e = ecnt0;
    send_bits(1'b0, 16'hFFFF, 0, 10, 1'b0);
    send_bits(1'b1, 16'h5555, 0, 16, 1'b0);
    checks++; if (ecnt0 - e !== 1) begin errors++; $display("FAIL short_err_count: got %0d expected 1", ecnt0 - e); end
    checks++; if (vcnt0 - b !== 0) begin errors++; $display("FAIL short_no_valid: got %0d expected 0", vcnt0 - b); end
    checks++; if (sl0 !== 16'h1234 || sr0 !== 16'hABCD) begin errors++; $display("FAIL short_hold: got %h/%h expected 1234/abcd", sl0, sr0); end
    send_frame(16'h0F0F, 16'h5555, 16, 1'b0);
    checks++; if (vcnt0 - b !== 1) begin errors++; $display("FAIL short_recover_count: got %0d expected 1", vcnt0 - b); end
    checks++; if (sl0 !== 16'h0F0F || sr0 !== 16'h5555) begin errors++; $display("FAIL short_recover_data: got %h/%h expected 0f0f/5555", sl0, sr0); end
    checks++; if (ecnt0 - e !== 1) begin errors++; $display("FAIL short_err_once: got %0d expected 1", ecnt0 - e); end
  endtask

  task automatic test_peak;
    int b;
    rst_one_pulsed = 1'b1; tick(2); rst_one_pulsed = 1'b0; tick(2);
    b = vcnt0;
    send_frame(16'd100, 16'h0000, 16, 1'b0);
    send_frame(16'hFED4, 16'h0000, 16, 1'b0);
    send_frame(16'h8000, 16'h0000, 16, 1'b0);
    checks++; if (pl0 !== 16'h0000) begin errors++; $display("FAIL peak_mid_window: got %h expected 0000", pl0); end
    send_frame(16'd5, 16'h0000, 16, 1'b0);
    checks++; if (vcnt0 - b !== 4) begin errors++; $display("FAIL peak_frames: got %0d expected 4", vcnt0 - b); end
    checks++; if (pl0 !== 16'h7FFF) begin errors++; $display("FAIL peak_left_sat: got %h expected 7fff", pl0); end
    checks++; if (pr0 !== 16'h0000) begin errors++; $display("FAIL peak_right_zero: got %h expected 0000", pr0); end
    for (int i = 0; i < 4; i++) send_frame(16'd7, 16'h0000, 16, 1'b0);
    checks++; if (pl0 !== 16'h0007) begin errors++; $display("FAIL peak_second_window: got %h expected 0007", pl0); end
  endtask

  task automatic test_reset_mid;
    int b;
    b = vcnt0;
    send_bits(1'b0, 16'h1111, 0, 16, 1'b0);
    send_bits(1'b1, 16'h2222, 0, 8, 1'b0);
    @(negedge clk);
    rst_one_pulsed = 1'b1;
    #1;
    checks++; if (sl0 !== 16'h0000 || pl0 !== 16'h0000 || sv0 !== 1'b0) begin errors++; $display("FAIL midreset_clear: got %h %h %b expected 0000 0000 0", sl0, pl0, sv0); end
    tick(2);
    rst_one_pulsed = 1'b0;
    send_bits(1'b1, 16'h2222, 8, 8, 1'b0);
    checks++; if (vcnt0 - b !== 0) begin errors++; $display("FAIL midreset_no_valid: got %0d expected 0", vcnt0 - b); end
    send_frame(16'h2468, 16'h1357, 16, 1'b0);
    checks++; if (vcnt0 - b !== 1 || sl0 !== 16'h2468 || sr0 !== 16'h1357) begin errors++; $display("FAIL midreset_recover: got %0d %h %h expected 1 2468 1357", vcnt0 - b, sl0, sr0); end
  endtask

  task automatic test_enable;
    int b, e;
    b = vcnt0; e = ecnt0;
    send_bits(1'b0, 16'h4444, 0, 8, 1'b0);
    @(negedge clk); en = 1'b0;
    @(negedge clk); en = 1'b1;
    send_bits(1'b0, 16'h4444, 8, 8, 1'b0);
    send_bits(1'b1, 16'h4545, 0, 16, 1'b0);
    checks++; if (vcnt0 - b !== 0 || ecnt0 - e !== 0) begin errors++; $display("FAIL en_drop: got valid %0d err %0d expected 0 0", vcnt0 - b, ecnt0 - e); end
    checks++; if (sl0 !== 16'h2468) begin errors++; $display("FAIL en_hold: got %h expected 2468", sl0); end
    send_frame(16'h4646, 16'h4747, 16, 1'b0);
    checks++; if (vcnt0 - b !== 1 || sl0 !== 16'h4646 || sr0 !== 16'h4747) begin errors++; $display("FAIL en_recover: got %0d %h %h expected 1 4646 4747", vcnt0 - b, sl0, sr0); end
  endtask

  task automatic test_loopback;
    logic [15:0] pat_l [6];
    logic [15:0] pat_r [6];
    int b;
    pat_l = '{16'h0001, 16'h7FFF, 16'hA5A5, 16'h0000, 16'hFEDC, 16'h8000};
    pat_r = '{16'hFFFF, 16'h8000, 16'h5A5A, 16'h1234, 16'h0123, 16'h7FFF};
    b = vcnt0;
    for (int i = 0; i < 6; i++) begin
      send_frame(pat_l[i], pat_r[i], 16, 1'b0);
      checks++; if (sl0 !== pat_l[i]) begin errors++; $display("FAIL loop_left[%0d]: got %h expected %h", i, sl0, pat_l[i]); end
      checks++; if (sr0 !== pat_r[i]) begin errors++; $display("FAIL loop_right[%0d]: got %h expected %h", i, sr0, pat_r[i]); end
    end
    checks++; if (vcnt0 - b !== 6) begin errors++; $display("FAIL loop_count: got %0d expected 6", vcnt0 - b); end
  endtask

  task automatic test_pulse_rules;
    checks++; if (viol0 !== 0) begin errors++; $display("FAIL back_to_back_pulses: got %0d expected 0", viol0); end
    checks++; if (chg0 !== 0) begin errors++; $display("FAIL output_stability: got %0d expected 0", chg0); end
  endtask

  initial begin
    test_reset();
    test_left_justified();
    test_delayed_wide();
    test_short_slot();
    test_peak();
    test_reset_mid();
    test_enable();
    test_loopback();
    test_pulse_rules();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/i2s_audio_receiver.md
# i2s_audio_receiver

- Deserialises a 16-bit, two-channel I2S-style serial stream (SCK/LRCK/SDIN), such as the one `speaker_control` transmits, back into parallel left/right samples in the `clk` domain.
- Also produces a windowed peak meter per channel.
- Used for audio loopback self-test of the speaker path and as the capture front-end for an external line-in ADC on the Pmod audio port.

## Interface

- `DATA_DELAY`, default 0 — number of SCK rising edges skipped after each LRCK edge before the MSB is sampled. Only 0 (left-justified) and 1 (Philips I2S) are legal.
- `PEAK_FRAMES`, default 4096 — number of valid stereo frames per peak-meter window. Must be ≥ 1 and ≤ 65536.

Ports (name, direction, width, meaning):

- `clk` in 1 — 100 MHz system clock.
- `rst_one_pulsed` in 1 — reset: asynchronous, active-high. Clock is `clk`.
- `en` in 1 — receive enable, synchronous to `clk`.
- `audio_sck` in 1 — serial clock, asynchronous. Period must be ≥ 8 clk.
- `audio_lrck` in 1 — word select, asynchronous. Low = left, high = right.
- `audio_sdin` in 1 — serial data, asynchronous. Changes on SCK falling edges; MSB first, two's complement.
- `sample_left` out 16 — last complete left sample.
- `sample_right` out 16 — last complete right sample.
- `sample_valid` out 1 — one-clk pulse; both sample outputs updated this cycle.
- `frame_err` out 1 — one-clk pulse; a slot ended with fewer than 16 captured bits.
- `peak_left` out 16 — max |left| over the last completed window.
- `peak_right` out 16 — max |right| over the last completed window.

## Operation

- **Synchronisers.** Each of sck, lrck and sdin passes through a 3-flop chain (s1→s2→s3).
  - SCK rise = s2 & ~s3.
  - LRCK rise = s2 & ~s3; LRCK fall = ~s2 & s3.
  - The data bit is sdin s2, sampled in the same cycle an SCK rise is detected.
- **FSM states:** IDLE, LEFT, RIGHT.
  - IDLE → LEFT on an LRCK fall while `en`=1. Every other event in IDLE is ignored, so the first slot is always left.
  - LEFT → RIGHT on an LRCK rise.
  - RIGHT → LEFT on an LRCK fall.
  - Any state → IDLE whenever `en`=0. Any partial word is discarded; outputs hold their values.
- **Bit counter and shift register.**
  - `bit_cnt` (5 bits, saturating at 31) clears on every LRCK edge and increments on every SCK rise.
  - A bit is shifted into the 16-bit shift register when `DATA_DELAY` ≤ `bit_cnt` < `DATA_DELAY`+16.
  - Bits beyond 16 in a slot are ignored (slots longer than 16 SCK are legal).
- **Simultaneous events.** If an LRCK edge and an SCK rise are detected in the same cycle, the LRCK edge is processed first. That SCK rise counts as edge 0 of the new slot.
- **Word completion.** A word completes on the cycle its 16th bit is shifted in.
  - Left word completes: it is stored in `left_hold` and `left_ok` is set.
  - Right word completes with `left_ok`=1: on the next clk, `sample_left` ← `left_hold`, `sample_right` ← the word, `sample_valid` pulses, and `left_ok` clears.
  - Right word completes with `left_ok`=0: it is discarded and no valid pulse is issued.
- **Short slot.** An LRCK edge arrives in LEFT or RIGHT before that slot's 16th bit.
  - `frame_err` pulses on the next clk.
  - The partial word is discarded.
  - A short left slot clears `left_ok`.
- **Peak meter.**
  - `abs` = two's-complement magnitude, with −32768 saturating to 32767.
  - On each `sample_valid`, `pk_l` ← max(`pk_l`, abs(left)) and `pk_r` likewise for right, and `frame_cnt` increments.
  - On the `PEAK_FRAMES`-th frame, the outputs take the max including that frame: `peak_left` ← max(`pk_l`, abs(left)), `peak_right` likewise.
  - On that same frame, `pk_l`, `pk_r` and `frame_cnt` clear.

## Timing

- **Reset** (async, immediate):
  - Outputs: all samples and peaks are 0, `sample_valid`=0, `frame_err`=0.
  - Internal: state IDLE, `bit_cnt`=0, `left_ok`=0, accumulators and `frame_cnt` are 0.
  - Synchronisers reset to 0. An LRCK that is high at release therefore appears as a rise, which is ignored in IDLE.
  - Reset mid-frame discards everything. Capture restarts at the next LRCK fall after release.
- **Latency, data:** `sample_valid` is high in the 4th clk cycle after the SCK pin edge carrying the 16th right-slot bit, with ±1 clk of synchroniser phase.
- **Latency, errors:** `frame_err` is high in the 4th clk cycle after the offending LRCK pin edge, ±1.
- **Output stability:** samples change only in `sample_valid` cycles. Peaks change only in window-end `sample_valid` cycles.
- **Pulse spacing:** `sample_valid` and `frame_err` are single-cycle pulses and can never be high in consecutive cycles.
- **`en` timing:** falling `en` takes effect on the next clk edge. Rising `en` requires a fresh LRCK fall before capture begins.

## Test plan

- **Left-justified capture.** `DATA_DELAY`=0, SCK=16 clk, 16 SCK per slot; send L=16'h8001, R=16'h7FFE.
  - Required: one `sample_valid` per frame; `sample_left`=16'h8001, `sample_right`=16'h7FFE.
  - Required: `sample_valid` lands 4±1 clk after the last right SCK rise.
- **Delayed, wide slot.** `DATA_DELAY`=1, 32 SCK per slot; send L=16'h1234, R=16'hABCD, fill bits =1.
  - Required: outputs equal 16'h1234 and 16'hABCD; `frame_err` never pulses.
- **Short slot.** Left slot truncated to 10 SCK, then a valid right slot of 16'h5555.
  - Required: one `frame_err` pulse; no `sample_valid`; outputs keep their previous values; the next full frame captures normally.
- **Peak meter.** `PEAK_FRAMES`=4; frames with left = 100, −300, 16'h8000, 5 and right = 0.
  - Required: after the 4th `sample_valid`, `peak_left`=32767 and `peak_right`=0.
  - Required: a following window of left = 7 gives `peak_left`=7.
- **Reset and enable.**
  - Assert `rst_one_pulsed` mid right slot → all outputs 0 immediately; no valid until a full frame that starts at an LRCK fall.
  - Drop `en` for 1 clk mid left slot → that frame is dropped; the next frame is captured.
- **Loopback.** Feed `speaker_control` outputs in with a known `audio_in_left`/`audio_in_right` pattern.
  - Required: the received samples match the pattern frame for frame after the first aligned frame.
